// File: rtl/pwm_led_dimmer.sv
// -----------------------------------------------------------------------------
// pwm_led_dimmer
//
// Multi-channel PWM LED dimmer controlled by three pushbuttons. Each raw button
// is synchronised, debounced and edge-detected into a single-cycle press
// pulse. Up/down presses step the selected channel's duty register, with
// saturation at both ends. The select press advances to the next channel. The
// PWM generator latches new duties only at the start of a period, so no runt
// or partial periods ever appear on the LED pins.
//
// Ports:
//   clk       board clock, the only clock
//   rst_n     synchronous active-low reset
//   btn_up    raw async button, raises the duty of the selected channel
//   btn_down  raw async button, lowers the duty of the selected channel
//   btn_sel   raw async button, advances the selected channel (wraps to 0)
//   led       registered PWM outputs, one bit per channel
//   led_ref   constant 1, full-brightness reference LED
//   sel       index of the currently selected channel
// -----------------------------------------------------------------------------
module pwm_led_dimmer #(
    parameter  int WIDTH           = 8,
    parameter  int CHANNELS        = 4,
    parameter  int STEP            = 16,
    parameter  int PRESCALE        = 1,
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int SEL_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_sel,
    output logic [CHANNELS-1:0] led,
    output logic                led_ref,
    output logic [SEL_W-1:0]    sel
);

    // Button lane indices within the packed button vectors.
    localparam int NBTN    = 3;
    localparam int BTN_UP  = 0;
    localparam int BTN_DN  = 1;
    localparam int BTN_SEL = 2;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH:0]   DUTY_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   STEP_WIDE = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_NAR  = WIDTH'(STEP);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(CHANNELS - 1);

    // -------------------------------------------------------------------------
    // Input conditioning: 2-flop synchroniser, debounce counter, rising-edge
    // detector on the debounced level.
    // -------------------------------------------------------------------------
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] stable_d;
    logic [NBTN-1:0] press;
    logic [DB_W-1:0] db_cnt [NBTN];

    assign btn_raw = {btn_sel, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int b = 0; b < NBTN; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every flop sample the value
            // from before this edge, which is what makes sync1 -> sync2 a real
            // two-stage chain instead of a single wire.
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            // Only a 0->1 change of the debounced level is a press; releases
            // and held levels produce nothing, so there is no auto-repeat.
            press    <= stable & ~stable_d;
            for (int b = 0; b < NBTN; b++) begin
                if (sync2[b] == stable[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    stable[b] <= ~stable[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating duty arithmetic. The up sum is formed one bit wider so that
    // an overflow is visible and clamped rather than wrapping.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sum;
        sum = {1'b0, d} + STEP_WIDE;
        return (sum > DUTY_MAX) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_down(input logic [WIDTH-1:0] d);
        return (d >= STEP_NAR) ? d - STEP_NAR : '0;
    endfunction

    // -------------------------------------------------------------------------
    // Channel select and duty registers. An up/down press that coincides with
    // a select press still targets the channel selected before the edge.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] duty_next [CHANNELS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel <= '0;
            // NOTE: the duty array is a handful of flops, not a RAM, so it is
            // cleared like any other register to give a defined dark start-up.
            for (int i = 0; i < CHANNELS; i++) begin
                duty_next[i] <= '0;
            end
        end else begin
            if (press[BTN_SEL]) begin
                sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (SEL_W'(i) == sel) begin
                    // Up and down together cancel out.
                    if (press[BTN_UP] && !press[BTN_DN]) begin
                        duty_next[i] <= sat_up(duty_next[i]);
                    end else if (press[BTN_DN] && !press[BTN_UP]) begin
                        duty_next[i] <= sat_down(duty_next[i]);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // PWM generation: prescaler -> tick -> period counter. Active duties are
    // reloaded only on the tick that wraps pwm_cnt back to 0.
    // -------------------------------------------------------------------------
    logic [PS_W-1:0]  presc;
    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] duty_act [CHANNELS];

    assign tick = (presc == PS_LAST);
    assign wrap = tick && (pwm_cnt == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
            led     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= '0;
            end
        end else begin
            presc <= tick ? '0 : presc + PS_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + WIDTH'(1);
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrap) begin
                    duty_act[i] <= duty_next[i];
                end
                // Registered compare: led lags pwm_cnt by one cycle.
                led[i] <= (pwm_cnt < duty_act[i]);
            end
        end
    end

    assign led_ref = 1'b1;

endmodule
